// File: rtl/cp0_exception_unit.sv
// Coprocessor 0 for the 5-stage MIPS pipeline: SR, Cause, EPC and PRId.
// It decides when to enter the exception handler and when to return through
// eret, and it serves mfc0/mtc0 in the M stage.
module cp0_exception_unit #(
  parameter logic [31:0] PRID     = 32'h2033_0001,
  parameter logic [31:0] SR_WMASK = 32'h0000_FC03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M_I,
  input  logic [8:2]  ExCode_M_I,
  input  logic [5:0]  HWInt_I,
  input  logic        eret_M_I,
  input  logic        CP0We_I,
  input  logic [4:0]  CP0Addr_I,
  input  logic [31:0] CP0WD_I,
  output logic [31:0] CP0RD_O,
  output logic [31:0] EPC_O,
  output logic        PCtoIn_O,
  output logic        PCBack_O
);

  // SR is kept as a full word. Bits outside SR_WMASK reset to 0 and are only
  // ever written back with their own value, so they always read as 0.
  logic [31:0] r_sr;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic [31:0] w_cause;
  logic        w_int_req;
  logic        w_exc_req;
  logic        w_take;
  logic        w_back;
  logic [31:0] w_epc_base;
  logic [31:0] w_sr_wr;
  logic        w_mt_sr;
  logic        w_mt_epc;

  assign w_cause = {r_cause_bd, 15'b0, r_cause_ip, 3'b0, r_cause_exc, 2'b00};

  // Request decode; EXL masks both request kinds. Reset gates the outputs
  // because ExCode can still request while the registers are held clear.
  assign w_int_req = (|(HWInt_I & r_sr[15:10])) & r_sr[0] & ~r_sr[1];
  assign w_exc_req = ExCode_M_I[7] & ~r_sr[1];
  assign w_take    = ~reset & (w_int_req | w_exc_req);
  assign w_back    = ~reset & eret_M_I & ~w_take;

  assign PCtoIn_O = w_take;
  assign PCBack_O = w_back;
  assign EPC_O    = r_epc;

  // Delay-slot exceptions restart at the branch, one word earlier.
  assign w_epc_base = ExCode_M_I[8] ? (PC_M_I - 32'd4) : PC_M_I;

  // An mtc0 in the same cycle as a taken exception never commits.
  assign w_mt_sr  = CP0We_I & ~w_take & (CP0Addr_I == 5'd12);
  assign w_mt_epc = CP0We_I & ~w_take & (CP0Addr_I == 5'd14);
  assign w_sr_wr  = (CP0WD_I & SR_WMASK) | (r_sr & ~SR_WMASK);

  // Register update: exception entry, eret return, and mtc0 writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr        <= '0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= '0;
      r_cause_exc <= '0;
      r_epc       <= '0;
    end else begin
      r_cause_ip <= HWInt_I;
      if (w_take) begin
        r_sr[1]     <= 1'b1;
        r_cause_bd  <= ExCode_M_I[8];
        r_cause_exc <= w_int_req ? 5'd0 : ExCode_M_I[6:2];
        r_epc       <= w_epc_base & ~32'd3;
      end else begin
        if (w_mt_sr) begin
          r_sr <= w_sr_wr;
        end
        // eret clears EXL even when an mtc0 to SR lands in the same cycle.
        if (w_back) begin
          r_sr[1] <= 1'b0;
        end
        if (w_mt_epc) begin
          r_epc <= CP0WD_I & ~32'd3;
        end
      end
    end
  end

  // mfc0 read mux; no bypass from a same-cycle mtc0.
  always_comb begin
    CP0RD_O = '0;
    case (CP0Addr_I)
      5'd12:   CP0RD_O = r_sr;
      5'd13:   CP0RD_O = w_cause;
      5'd14:   CP0RD_O = r_epc;
      5'd15:   CP0RD_O = PRID;
      default: CP0RD_O = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed-vector bench for cp0_exception_unit.
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID = 32'h2033_0001;

  logic        clk;
  logic        reset;
  logic [31:0] PC_M_I;
  logic [8:2]  ExCode_M_I;
  logic [5:0]  HWInt_I;
  logic        eret_M_I;
  logic        CP0We_I;
  logic [4:0]  CP0Addr_I;
  logic [31:0] CP0WD_I;
  logic [31:0] CP0RD_O;
  logic [31:0] EPC_O;
  logic        PCtoIn_O;
  logic        PCBack_O;

  int unsigned n_vec;
  int unsigned n_err;

  cp0_exception_unit #(
    .PRID     (PRID),
    .SR_WMASK (32'h0000_FC03)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PC_M_I     (PC_M_I),
    .ExCode_M_I (ExCode_M_I),
    .HWInt_I    (HWInt_I),
    .eret_M_I   (eret_M_I),
    .CP0We_I    (CP0We_I),
    .CP0Addr_I  (CP0Addr_I),
    .CP0WD_I    (CP0WD_I),
    .CP0RD_O    (CP0RD_O),
    .EPC_O      (EPC_O),
    .PCtoIn_O   (PCtoIn_O),
    .PCBack_O   (PCBack_O)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 ns later, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mfc0 read; only used while CP0We_I is low.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    CP0Addr_I = a;
    #1;
    chk(tag, CP0RD_O, exp);
  endtask

  task automatic idle();
    ExCode_M_I = '0;
    eret_M_I   = 1'b0;
    CP0We_I    = 1'b0;
    CP0Addr_I  = '0;
    CP0WD_I    = '0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    CP0We_I   = 1'b1;
    CP0Addr_I = a;
    CP0WD_I   = d;
    tick();
    CP0We_I   = 1'b0;
    CP0WD_I   = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    PC_M_I = 32'h0000_3000;
    HWInt_I = 6'h3F;
    idle();
    ExCode_M_I = 7'b0100000;
    eret_M_I   = 1'b1;
    reset      = 1'b1;

    // 1. Reset with interrupts and an exception pending
    tick(); tick();
    chk("rst_pctoin", {31'b0, PCtoIn_O}, 32'd0);
    chk("rst_pcback", {31'b0, PCBack_O}, 32'd0);
    rd("rst_sr", 5'd12, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_prid", 5'd15, PRID);
    idle();
    HWInt_I = '0;
    #1 reset = 1'b0;
    tick();

    // 2. AdEL on fetch, not in a delay slot
    PC_M_I = 32'h0000_3002;
    ExCode_M_I = {1'b0, 1'b1, 5'd4};
    #1 chk("adel_pctoin", {31'b0, PCtoIn_O}, 32'd1);
    tick();
    idle();
    chk("adel_epc_o", EPC_O, 32'h0000_3000);
    rd("adel_epc", 5'd14, 32'h0000_3000);
    rd("adel_cause", 5'd13, 32'h0000_0010);
    rd("adel_sr", 5'd12, 32'h0000_0002);

    // Return: eret with EXL=1
    eret_M_I = 1'b1;
    #1 chk("eret1_pcback", {31'b0, PCBack_O}, 32'd1);
    tick();
    idle();
    rd("eret1_sr", 5'd12, 32'd0);

    // 3. Exception in a delay slot
    PC_M_I = 32'h0000_3010;
    ExCode_M_I = {1'b1, 1'b1, 5'd10};
    tick();
    idle();
    rd("bd_epc", 5'd14, 32'h0000_300C);
    rd("bd_cause", 5'd13, 32'h8000_0028);
    eret_M_I = 1'b1;
    tick();
    idle();

    // 4. Interrupt with IM[10] and IE enabled
    mtc0(5'd12, 32'h0000_0401);
    rd("mt_sr", 5'd12, 32'h0000_0401);
    PC_M_I  = 32'h0000_4000;
    HWInt_I = 6'b000001;
    #1 chk("int_pctoin", {31'b0, PCtoIn_O}, 32'd1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_sr", 5'd12, 32'h0000_0403);
    rd("int_epc", 5'd14, 32'h0000_4000);
    chk("int_exl_mask", {31'b0, PCtoIn_O}, 32'd0);
    HWInt_I  = '0;
    eret_M_I = 1'b1;
    tick();
    idle();
    mtc0(5'd12, 32'h0000_0400);
    HWInt_I = 6'b000001;
    #1 chk("int_ie0_mask", {31'b0, PCtoIn_O}, 32'd0);
    tick();
    rd("ip_snapshot", 5'd13, 32'h0000_0400);
    HWInt_I = '0;

    // 5. Interrupt + exception + mtc0 EPC in one cycle
    mtc0(5'd12, 32'h0000_0401);
    PC_M_I     = 32'h0000_6004;
    HWInt_I    = 6'b000001;
    ExCode_M_I = {1'b0, 1'b1, 5'd12};
    CP0We_I    = 1'b1;
    CP0Addr_I  = 5'd14;
    CP0WD_I    = 32'h0000_5000;
    #1 chk("sim_pctoin", {31'b0, PCtoIn_O}, 32'd1);
    tick();
    idle();
    HWInt_I = '0;
    rd("sim_epc", 5'd14, 32'h0000_6004);
    rd("sim_cause", 5'd13, 32'h0000_0400);
    rd("sim_sr", 5'd12, 32'h0000_0403);

    // 6. eret with EXL=1, EPC written by mtc0, SR mtc0 in the eret cycle
    mtc0(5'd14, 32'h0000_300B);
    chk("mt_epc_o", EPC_O, 32'h0000_3008);
    eret_M_I  = 1'b1;
    CP0We_I   = 1'b1;
    CP0Addr_I = 5'd12;
    CP0WD_I   = 32'h0000_0C03;
    #1 chk("eret_pcback", {31'b0, PCBack_O}, 32'd1);
    chk("eret_epc_o", EPC_O, 32'h0000_3008);
    tick();
    idle();
    rd("eret_sr", 5'd12, 32'h0000_0C01);

    // eret with EXL=0 still returns; EXL stays 0
    eret_M_I = 1'b1;
    #1 chk("eret_exl0", {31'b0, PCBack_O}, 32'd1);
    tick();
    idle();
    rd("eret_exl0_sr", 5'd12, 32'h0000_0C01);

    // eret + exception together: exception wins
    PC_M_I     = 32'h0000_7000;
    eret_M_I   = 1'b1;
    ExCode_M_I = {1'b0, 1'b1, 5'd5};
    #1 chk("ee_pctoin", {31'b0, PCtoIn_O}, 32'd1);
    chk("ee_pcback", {31'b0, PCBack_O}, 32'd0);
    tick();
    idle();
    rd("ee_epc", 5'd14, 32'h0000_7000);
    rd("ee_sr", 5'd12, 32'h0000_0C03);
    rd("ee_cause", 5'd13, 32'h0000_0014);

    // Unimplemented / read-only registers
    mtc0(5'd15, 32'hFFFF_FFFF);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("ro_prid", 5'd15, PRID);
    rd("ro_cause", 5'd13, 32'h0000_0014);
    rd("unimpl", 5'd3, 32'd0);

    // Reset mid-handler clears EXL and EPC immediately
    #3 reset = 1'b1;
    ExCode_M_I = {1'b0, 1'b1, 5'd4};
    #1 rd("mrst_sr", 5'd12, 32'd0);
    chk("mrst_epc", EPC_O, 32'd0);
    chk("mrst_pctoin", {31'b0, PCtoIn_O}, 32'd0);
    tick();
    idle();
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
